alu_ctrl_seq: RTL and testbench

ALU_CTRL_SEQ -- requirements
Module: alu_ctrl_seq

---
 rtl/alu_ctrl_seq.sv | 156 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequencer for a 16-slice ALU.
// Decodes an opcode/funct pair into slice controls, holds them for a settle
// cycle, captures the slice result and reports completion with a Done pulse.
//
// Timeline for a request whose Start is sampled at edge N:
//   edge N   : IDLE -> DRIVE, controls latched, Busy rises
//   edge N+1 : DRIVE -> CAPTURE
//   edge N+2 : CAPTURE -> DONE, Dalja/overflow captured into result regs
//   edge N+3 : DONE -> IDLE, Done pulses high for the following cycle
// Because every output is a register, Done becomes visible after edge N+3 and
// coincides with the first IDLE cycle, so a new Start can be taken at N+4.
// A request is accepted only when Start is high in IDLE; Start while Busy is
// dropped, never queued.
module alu_ctrl_seq (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [3:0]  i_opcode,
  input  logic [2:0]  i_funct,
  input  logic [15:0] i_dalja,
  input  logic        i_alu_overflow,
  output logic [2:0]  o_alu_ctrl,
  output logic        o_binvert,
  output logic        o_cin,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_rezultati,
  output logic        o_zero,
  output logic        o_overflow,
  output logic        o_err,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_alu_ctrl;
  logic        r_binvert;
  logic        r_cin;
  logic        r_illegal;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_rezultati;
  logic        r_zero;
  logic        r_overflow;
  logic        r_err;

  logic [2:0]  w_dec_ctrl;
  logic        w_dec_binv;
  logic        w_dec_cin;
  logic        w_dec_illegal;
  logic        w_addsub;

  // Opcode/funct decode into {AluCtrl, Binvert, CIN}; unknown codes decode to zeros and flag illegal.
  always_comb begin
    w_dec_ctrl    = 3'b000;
    w_dec_binv    = 1'b0;
    w_dec_cin     = 1'b0;
    w_dec_illegal = 1'b0;
    case (i_opcode)
      4'b0000: begin
        case (i_funct)
          3'b000:  w_dec_ctrl = 3'b000;
          3'b001:  w_dec_ctrl = 3'b010;
          3'b010:  w_dec_ctrl = 3'b011;
          3'b011:  w_dec_ctrl = 3'b100;
          3'b100:  begin w_dec_ctrl = 3'b100; w_dec_binv = 1'b1; w_dec_cin = 1'b1; end
          3'b101:  begin w_dec_ctrl = 3'b110; w_dec_binv = 1'b1; w_dec_cin = 1'b1; end
          default: w_dec_illegal = 1'b1;
        endcase
      end
      4'b0100: w_dec_ctrl = 3'b100;
      4'b0101: begin w_dec_ctrl = 3'b001; w_dec_binv = 1'b1; w_dec_cin = 1'b1; end
      4'b0110: w_dec_ctrl = 3'b000;
      4'b0111: w_dec_ctrl = 3'b010;
      4'b1000,
      4'b1001: w_dec_ctrl = 3'b100;
      4'b1010: begin w_dec_ctrl = 3'b100; w_dec_binv = 1'b1; w_dec_cin = 1'b1; end
      default: w_dec_illegal = 1'b1;
    endcase
  end

  // Overflow is only meaningful when the slices are in ADD/SUB mode (AluCtrl 10x).
  assign w_addsub = (r_alu_ctrl[2:1] == 2'b10);

  // Request sequencer: state and all registered outputs in one block.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_alu_ctrl  <= 3'b000;
      r_binvert   <= 1'b0;
      r_cin       <= 1'b0;
      r_illegal   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rezultati <= 16'h0000;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_alu_ctrl <= w_dec_ctrl;
            r_binvert  <= w_dec_binv;
            r_cin      <= w_dec_cin;
            r_illegal  <= w_dec_illegal;
            r_busy     <= 1'b1;
            r_state    <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (r_illegal) begin
            r_rezultati <= 16'h0000;
            r_zero      <= 1'b0;
            r_overflow  <= 1'b0;
            r_err       <= 1'b1;
          end else begin
            r_rezultati <= i_dalja;
            r_zero      <= (i_dalja == 16'h0000);
            r_overflow  <= w_addsub & i_alu_overflow;
            r_err       <= 1'b0;
          end
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_alu_ctrl  = r_alu_ctrl;
  assign o_binvert   = r_binvert;
  assign o_cin       = r_cin;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rezultati = r_rezultati;
  assign o_zero      = r_zero;
  assign o_overflow  = r_overflow;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: a table of decode/capture vectors plus
// hand-written sequences for Start-while-busy, back-to-back, hold-in-idle and
// asynchronous reset abort.
module tb_alu_ctrl_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [2:0]  funct;
  logic [15:0] dalja;
  logic        aovf;
  logic [2:0]  alu_ctrl;
  logic        binvert;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] rezultati;
  logic        zero;
  logic        overflow;
  logic        err;
  logic [1:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  alu_ctrl_seq dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_opcode       (opcode),
    .i_funct        (funct),
    .i_dalja        (dalja),
    .i_alu_overflow (aovf),
    .o_alu_ctrl     (alu_ctrl),
    .o_binvert      (binvert),
    .o_cin          (cin),
    .o_busy         (busy),
    .o_done         (done),
    .o_rezultati    (rezultati),
    .o_zero         (zero),
    .o_overflow     (overflow),
    .o_err          (err),
    .o_state        (state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [2:0]  fn;
    logic [15:0] d;
    logic        ov;
    logic [2:0]  e_ctrl;
    logic        e_binv;
    logic        e_cin;
    logic [15:0] e_rez;
    logic        e_zero;
    logic        e_ovf;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] all_outs();
    return {alu_ctrl, binvert, cin, busy, done, rezultati, zero, overflow, err};
  endfunction

  // Driver: one full request; checks controls after edge N, Done latency and captured results.
  task automatic run_vec(input vec_t v);
    int lat;
    logic [15:0] e;
    @(negedge clk);
    opcode = v.op; funct = v.fn; dalja = v.d; aovf = v.ov; start = 1'b1;
    exp_q.push_back(v.e_rez);
    @(posedge clk);
    #1 start = 1'b0;
    chk({v.name, ".ctrl"}, {29'd0, alu_ctrl}, {29'd0, v.e_ctrl});
    chk({v.name, ".binv_cin"}, {30'd0, binvert, cin}, {30'd0, v.e_binv, v.e_cin});
    chk({v.name, ".busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
    end
    chk({v.name, ".latency"}, lat, (done ? 32'd3 : 32'd99));
    chk({v.name, ".done_seen"}, {31'd0, done}, 32'd1);
    e = exp_q.pop_front();
    chk({v.name, ".rez"}, {16'd0, rezultati}, {16'd0, e});
    chk({v.name, ".flags"}, {29'd0, zero, overflow, err}, {29'd0, v.e_zero, v.e_ovf, v.e_err});
    chk({v.name, ".busy_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 chk({v.name, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; opcode = '0; funct = '0; dalja = '0; aovf = 1'b0;

    //              name      op     fn      d        ov    ctrl    bi    ci    rez      z     ovf   err
    vecs.push_back('{"sub",   4'h0, 3'd4, 16'h0000, 1'b0, 3'b100, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"slti",  4'h5, 3'd0, 16'h0001, 1'b1, 3'b001, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"illop", 4'hF, 3'd0, 16'hBEEF, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"and",   4'h0, 3'd0, 16'h1234, 1'b1, 3'b000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"add",   4'h0, 3'd3, 16'h8000, 1'b1, 3'b100, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"or",    4'h0, 3'd1, 16'h00F0, 1'b0, 3'b010, 1'b0, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"xor",   4'h0, 3'd2, 16'h0F0F, 1'b1, 3'b011, 1'b0, 1'b0, 16'h0F0F, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"slt",   4'h0, 3'd5, 16'h0001, 1'b1, 3'b110, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"fn110", 4'h0, 3'd6, 16'h7777, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"addi",  4'h4, 3'd7, 16'h0000, 1'b1, 3'b100, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"fn111", 4'h0, 3'd7, 16'h1111, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"andi",  4'h6, 3'd0, 16'hA5A5, 1'b1, 3'b000, 1'b0, 1'b0, 16'hA5A5, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"ori",   4'h7, 3'd0, 16'h0000, 1'b0, 3'b010, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"lw",    4'h8, 3'd0, 16'h4000, 1'b1, 3'b100, 1'b0, 1'b0, 16'h4000, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"sw",    4'h9, 3'd0, 16'h0010, 1'b0, 3'b100, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{"beq",   4'hA, 3'd0, 16'h0000, 1'b1, 3'b100, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"ill01", 4'h1, 3'd0, 16'hFFFF, 1'b1, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{"andclr",4'h0, 3'd0, 16'h00FF, 1'b0, 3'b000, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0});

    // Reset state, checked while reset is held
    #12;
    chk("reset.outs", {6'd0, all_outs()}, 32'd0);
    chk("reset.state", {30'd0, state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; the first one is the first Start after reset release
    foreach (vecs[i]) run_vec(vecs[i]);

    // Start held high through N+1 and N+2 of an ADD: ignored; Start at N+4 accepted, Done at N+7
    @(negedge clk);
    opcode = 4'h0; funct = 3'd3; dalja = 16'h0100; aovf = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 opcode = 4'h0; funct = 3'd2;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (c == 2) begin
        chk("busy_start.ctrl_kept", {29'd0, alu_ctrl}, 32'd4);
        start = 1'b0;
      end
      if (c == 3) begin
        chk("busy_start.done_n3", {31'd0, done}, 32'd1);
        chk("busy_start.rez", {16'd0, rezultati}, 32'h0100);
        opcode = 4'h0; funct = 3'd0; dalja = 16'h00FF; start = 1'b1;
      end
      if (c == 4) begin
        start = 1'b0;
        chk("b2b.accepted", {28'd0, busy, alu_ctrl}, {28'd0, 1'b1, 3'b000});
      end
      if (c == 7) begin
        chk("b2b.done_n7", {31'd0, done}, 32'd1);
        chk("b2b.rez", {16'd0, rezultati}, 32'h00FF);
      end
    end
    chk("busy_start.done_count", ndone, 32'd2);

    // Controls and results hold in IDLE after completion
    repeat (2) @(posedge clk);
    #1 chk("hold.outs", {6'd0, all_outs()}, {6'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0, 1'b0});

    // Asynchronous reset during CAPTURE aborts the request with no Done
    @(negedge clk);
    opcode = 4'h0; funct = 3'd4; dalja = 16'h5555; aovf = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 chk("abort.in_capture", {30'd0, state}, 32'd2);
    rst_n = 1'b0;
    #1 chk("abort.outs_async", {6'd0, all_outs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("abort.no_done", ndone, 32'd0);
    chk("abort.idle", {6'd0, all_outs()}, 32'd0);

    // First Start after reset release is taken
    run_vec('{"post_rst", 4'h0, 3'd3, 16'h0042, 1'b0, 3'b100, 1'b0, 1'b0, 16'h0042, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
